fetch_queue: RTL and testbench

Instruction prefetch stage between a variable-latency instruction memory port and the IF/ID pipeline register. It owns the fetch PC, issues sequential word fetches ahead of decode, and buffers returned instructions with their PCs in a FIFO. It drops in-flight fetches on a branch redirect from the EX-stage branch unit, and holds its output when the hazard detection unit stalls IF/ID.

---
 rtl/fetch_queue_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/fetch_queue.sv | 145 ++++++++++++++
 tb/tb_fetch_queue.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_queue_pkg;

  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // RUN: normal fetch. FLUSH: responses of pre-redirect fetches are still
  // in flight and are being discarded.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fq_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is a combinational read.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must never push when full or pop when empty.
// Ports: clk/reset (async, active-low); push/push_data write; pop advances the head;
//        flush empties the FIFO and overrides push/pop; head/count report occupancy.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: issues sequential word fetches and buffers {pc, inst} for decode.
// Latency: response to inst_valid is 1 cycle (registered head, bypass when buffer empty).
// Backpressure: deq_ready=0 holds inst_*; issue stalls once in-flight + buffered reaches DEPTH.
// Ports: clk/reset (async, active-low); mem_req_* request channel (address held while
//        stalled); mem_rsp_* in-order responses; redirect_* flush and new PC from the branch
//        unit; deq_ready from hazard logic; inst_valid/inst_pc/inst_o registered head.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            deq_ready,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_o
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;

  fq_state_t       state, state_nxt;
  logic            issue_en;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt, drop_nxt;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   ent_count, tag_count;
  logic [CW1-1:0]  credit_used;
  fq_entry_t       ent_head, rsp_entry;
  logic [XLEN-1:0] tag_head;
  logic            ent_empty;
  logic            accept, rsp_live, rsp_drop, load_out, ent_pop, ent_push;

  // Every in-flight request is either a live one (its PC tag is queued) or a
  // stale one from before a redirect (counted in drop_cnt).
  assign outstanding = tag_count + drop_cnt;
  assign ent_empty   = (ent_count == '0);

  // Output register counts as a buffer slot so DEPTH covers all held entries.
  assign credit_used = {1'b0, outstanding} + {1'b0, ent_count} + CW1'(inst_valid);

  // issue_en keeps the request idle until the first edge after reset release.
  assign mem_req_valid = issue_en && !redirect_valid &&
                         (credit_used < CW1'(DEPTH)) && (outstanding < CW'(MAX_OUT));
  assign mem_req_addr  = fetch_pc;
  assign accept        = mem_req_valid && mem_req_ready;

  assign rsp_drop  = mem_rsp_valid && (drop_cnt != '0);
  assign rsp_live  = mem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign rsp_entry = '{pc: tag_head, inst: mem_rsp_data};

  // The head register reloads when empty or being consumed; the buffer feeds it
  // first, otherwise a live response bypasses straight in.
  assign load_out = !redirect_valid && (!inst_valid || deq_ready);
  assign ent_pop  = load_out && !ent_empty;
  assign ent_push = rsp_live && !(load_out && ent_empty);

  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect_valid) begin
      // Everything still unanswered after this edge belongs to the old stream.
      drop_nxt = outstanding + CW'(accept) - CW'(mem_rsp_valid);
    end else if (rsp_drop) begin
      drop_nxt = drop_cnt - CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (redirect_valid && (drop_nxt != '0)) state_nxt = FLUSH;
      FLUSH:   if (!redirect_valid && (drop_nxt == '0)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      issue_en   <= 1'b0;
      fetch_pc   <= RESET_PC;
      drop_cnt   <= '0;
      inst_valid <= 1'b0;
      inst_pc    <= '0;
      inst_o     <= '0;
    end else begin
      state    <= state_nxt;
      issue_en <= 1'b1;
      drop_cnt <= drop_nxt;

      if (redirect_valid) fetch_pc <= redirect_pc & ~XLEN'(WORD_BYTES - 1);
      else if (accept)    fetch_pc <= fetch_pc + XLEN'(WORD_BYTES);

      if (redirect_valid) begin
        inst_valid <= 1'b0;
      end else if (load_out) begin
        if (!ent_empty) begin
          inst_valid <= 1'b1;
          inst_pc    <= ent_head.pc;
          inst_o     <= ent_head.inst;
        end else if (rsp_live) begin
          inst_valid <= 1'b1;
          inst_pc    <= tag_head;
          inst_o     <= mem_rsp_data;
        end else begin
          inst_valid <= 1'b0;
        end
      end
    end
  end

  // PC of each live request, consumed in order as its response returns.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_live),
    .flush     (redirect_valid),
    .head      (tag_head),
    .count     (tag_count)
  );

  sync_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(DEPTH)) u_ent_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ent_push),
    .push_data (rsp_entry),
    .pop       (ent_pop),
    .flush     (redirect_valid),
    .head      (ent_head),
    .count     (ent_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order, fixed-latency memory responder.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data  = 32'd0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_o;

  fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_o         (inst_o)
  );

  always #5 clk = ~clk;

  int n_tests   = 0;
  int n_fail    = 0;
  int lat       = 1;
  int cyc       = 0;
  int acc_total = 0;
  int mark      = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] deq_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wait_out2(input string tag);
    int k = 0;
    while (!(dut.outstanding == 2 && !mem_rsp_valid) && k < 40) begin
      step();
      k++;
    end
    chk(tag, 32'(k < 40), 32'd1);
  endtask

  task automatic wait_inst(input string tag);
    int k = 0;
    while (!inst_valid && k < 40) begin
      step();
      k++;
    end
    chk(tag, 32'(k < 40), 32'd1);
  endtask

  // Memory: accepts are recorded mid-cycle, responses appear lat cycles later.
  always @(negedge clk) begin
    if (reset && mem_req_valid && mem_req_ready) begin
      mq_addr.push_back(mem_req_addr);
      mq_due.push_back(cyc + lat);
      acc_total++;
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      mq_addr.delete();
      mq_due.delete();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'd0;
    end else if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'd0;
    end
  end

  // Every consumed instruction must carry the word fetched from its own PC.
  always @(negedge clk) begin
    if (reset && inst_valid && deq_ready) begin
      deq_log.push_back(inst_pc);
      chk("inst_o_vs_pc", inst_o, mem_word(inst_pc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    deq_ready      = 1'b0;
    #2;
    reset = 1'b0;
    step(2);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_o", inst_o, 32'd0);

    // 1: single-cycle memory, free-flowing decode
    mem_req_ready = 1'b1;
    deq_ready     = 1'b1;
    reset         = 1'b1;
    step();
    chk("t1_req_valid", 32'(mem_req_valid), 32'd1);
    chk("t1_addr0", mem_req_addr, 32'h0);
    step();
    chk("t1_addr1", mem_req_addr, 32'h4);
    chk("t1_no_inst_yet", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_inst_pc", inst_pc, 32'(4 * i));
      chk("t1_out_le1", 32'(dut.outstanding <= 1), 32'd1);
    end

    // 2: decode stalled for 10 cycles
    deq_ready = 1'b0;
    step();
    chk("t2_hold_pc", inst_pc, 32'h8);
    step(9);
    chk("t2_hold_pc_end", inst_pc, 32'h8);
    chk("t2_hold_valid", 32'(inst_valid), 32'd1);
    chk("t2_no_issue", 32'(mem_req_valid), 32'd0);
    chk("t2_accepted", 32'(acc_total), 32'd6);
    chk("t2_buffered", 32'(dut.ent_count), 32'd3);
    deq_ready = 1'b1;
    step(6);
    chk("t2_inst_pc", inst_pc, 32'h20);
    chk("t2_log_len", 32'(deq_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("t2_log", deq_log[i], 32'(4 * i));

    // 3: 3-cycle memory, redirect with two fetches in flight
    lat = 3;
    wait_out2("t3_wait_out2");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("t3_no_req_in_redirect", 32'(mem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("t3_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    chk("t3_flushed", 32'(inst_valid), 32'd0);
    chk("t3_state_flush", 32'(dut.state), 32'(FLUSH));
    wait_inst("t3_wait_inst");
    chk("t3_first_pc", inst_pc, 32'h100);
    chk("t3_drop_zero", 32'(dut.drop_cnt), 32'd0);
    chk("t3_state_run", 32'(dut.state), 32'(RUN));

    // 4: redirect coincident with a response, 1-cycle memory
    lat = 1;
    step(6);
    begin
      int k = 0;
      while (!(mem_rsp_valid && dut.outstanding == 1) && k < 40) begin
        step();
        k++;
      end
      chk("t4_wait_rsp", 32'(k < 40), 32'd1);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h180;
    #1;
    chk("t4_no_req_in_redirect", 32'(mem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("t4_drop_cnt", 32'(dut.drop_cnt), 32'd0);
    chk("t4_flushed", 32'(inst_valid), 32'd0);
    step();
    chk("t4_next_addr", mem_req_addr, 32'h184);
    chk("t4_still_empty", 32'(inst_valid), 32'd0);
    step();
    chk("t4_first_valid", 32'(inst_valid), 32'd1);
    chk("t4_first_pc", inst_pc, 32'h180);

    // 5: back-to-back redirects while flushing; second one misaligned
    lat = 3;
    wait_out2("t5_wait_out2");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_pc = 32'h302;
    chk("t5_drop_after_1st", 32'(dut.drop_cnt), 32'd2);
    chk("t5_rsp_in_2nd", 32'(mem_rsp_valid), 32'd1);
    step();
    redirect_valid = 1'b0;
    chk("t5_drop_after_2nd", 32'(dut.drop_cnt), 32'd1);
    chk("t5_state_flush", 32'(dut.state), 32'(FLUSH));
    chk("t5_fetch_aligned", mem_req_addr, 32'h300);
    mark = deq_log.size();
    wait_inst("t5_wait_inst");
    chk("t5_first_pc", inst_pc, 32'h300);
    chk("t5_drop_zero", 32'(dut.drop_cnt), 32'd0);
    chk("t5_state_run", 32'(dut.state), 32'(RUN));
    step(20);
    chk("t5_log_len", 32'(deq_log.size() - mark >= 3), 32'd1);
    for (int i = 0; i < 3; i++) chk("t5_log", deq_log[mark + i], 32'h300 + 32'(4 * i));

    // 6: asynchronous reset mid-stream, then restart with a stalled request port
    deq_ready = 1'b0;
    wait_out2("t6_wait_out2");
    reset = 1'b0;
    #1;
    chk("t6_req_valid", 32'(mem_req_valid), 32'd0);
    chk("t6_inst_valid", 32'(inst_valid), 32'd0);
    chk("t6_inst_pc", inst_pc, 32'd0);
    chk("t6_inst_o", inst_o, 32'd0);
    chk("t6_outstanding", 32'(dut.outstanding), 32'd0);
    mem_req_ready = 1'b0;
    lat           = 1;
    deq_ready     = 1'b1;
    step(2);
    reset = 1'b1;
    step();
    chk("t6_req_valid_restart", 32'(mem_req_valid), 32'd1);
    chk("t6_addr_restart", mem_req_addr, 32'h0);
    step(2);
    chk("t6_addr_held", mem_req_addr, 32'h0);
    chk("t6_valid_held", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    step();
    chk("t6_addr_after_acc", mem_req_addr, 32'h4);
    chk("t6_not_yet", 32'(inst_valid), 32'd0);
    step();
    chk("t6_first_pc", inst_pc, 32'h0);
    chk("t6_first_valid", 32'(inst_valid), 32'd1);

    // PC wrap at the top of the address space, misaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr_top", mem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_flushed", 32'(inst_valid), 32'd0);
    step();
    chk("wrap_addr_zero", mem_req_addr, 32'h0);
    step();
    chk("wrap_inst_top", inst_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_inst_zero", inst_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
